// File: rtl/pmic_init_sequencer.sv
// pmic_init_sequencer: walks a fixed PMIC register-write table through i2c_handler.
// Optional per-entry retry on NACK/timeout is compiled in when SEQ_RETRY_EN is defined.
module pmic_init_sequencer #(
  parameter int NUM_ENTRIES    = 8,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 16,
  parameter int MAX_RETRIES    = 2
) (
  input  logic             i_clk,
  input  logic             i_resetN,
  input  logic             i_start,
  output logic [IDX_W-1:0] o_index,
  input  logic [22:0]      i_entry,
  output logic             o_begin,
  output logic             o_writeEnable,
  output logic [6:0]       o_i2cAddress,
  output logic [7:0]       o_regAddr,
  output logic [7:0]       o_data,
  input  logic             i_done,
  input  logic             i_nack,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [IDX_W-1:0] o_failIndex
);

  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (NUM_ENTRIES < 1 || NUM_ENTRIES > (1 << IDX_W) || TIMEOUT_CYCLES < 1 ||
      GAP_CYCLES < 0 || MAX_RETRIES < 0) begin : g_param_check
    $error("pmic_init_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  // With no inter-transaction gap the sequencer goes straight back to FETCH.
  localparam state_t S_AFTER = (GAP_CYCLES > 0) ? S_GAP : S_FETCH;

  state_t             state_r, next_state_s;
  logic [IDX_W-1:0]   index_r, fail_index_r;
  logic               busy_r, done_r, error_r, begin_r;
  logic [6:0]         addr_r;
  logic [7:0]         reg_r, data_r;
  logic [TO_W-1:0]    timeout_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               launch_s, advance_s, finish_s, abort_s;
  logic               ok_s, fail_s, last_s, timeout_s, gap_done_s, retry_ok_s;

  assign last_s     = (index_r == IDX_W'(NUM_ENTRIES - 1));
  assign timeout_s  = (timeout_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  assign gap_done_s = (gap_cnt_r == GAP_W'(GAP_CYCLES - 1));
  // A done pulse on the timeout cycle wins over the timeout.
  assign ok_s       = (state_r == S_WAIT) && i_done && !i_nack;
  assign fail_s     = (state_r == S_WAIT) && ((i_done && i_nack) || (!i_done && timeout_s));

`ifdef SEQ_RETRY_EN
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RTY_W-1:0] retry_cnt_r;

  assign retry_ok_s = (retry_cnt_r < RTY_W'(MAX_RETRIES));

  // Attempts already spent on the current entry.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      retry_cnt_r <= {RTY_W{1'b0}};
    end else if (launch_s || advance_s) begin
      retry_cnt_r <= {RTY_W{1'b0}};
    end else if (fail_s && retry_ok_s) begin
      retry_cnt_r <= retry_cnt_r + RTY_W'(1);
    end
  end
`else
  assign retry_ok_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and one-cycle control strobes.
  always_comb begin
    next_state_s = state_r;
    launch_s     = 1'b0;
    advance_s    = 1'b0;
    finish_s     = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          next_state_s = S_FETCH;
          launch_s     = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      S_FETCH: next_state_s = S_ISSUE;
      S_ISSUE: next_state_s = S_WAIT;
      S_WAIT: begin
        if (ok_s) begin
          if (last_s) begin
            next_state_s = S_DONE;
            finish_s     = 1'b1;
          end else begin
            next_state_s = S_AFTER;
            advance_s    = 1'b1;
          end
        end else if (fail_s) begin
          if (retry_ok_s) begin
            next_state_s = S_AFTER;
          end else begin
            next_state_s = S_ERROR;
            abort_s      = 1'b1;
          end
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_GAP: begin
        if (gap_done_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_GAP;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Status, index, payload and counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      begin_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      index_r       <= {IDX_W{1'b0}};
      fail_index_r  <= {IDX_W{1'b0}};
      addr_r        <= 7'd0;
      reg_r         <= 8'd0;
      data_r        <= 8'd0;
      timeout_cnt_r <= {TO_W{1'b0}};
      gap_cnt_r     <= {GAP_W{1'b0}};
    end else begin
      begin_r <= (next_state_s == S_ISSUE);
      if (launch_s) begin
        index_r <= {IDX_W{1'b0}};
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
        error_r <= 1'b0;
      end else if (advance_s) begin
        index_r <= index_r + IDX_W'(1);
      end else if (finish_s) begin
        done_r <= 1'b1;
        busy_r <= 1'b0;
      end else if (abort_s) begin
        error_r      <= 1'b1;
        fail_index_r <= index_r;
        busy_r       <= 1'b0;
      end
      if (state_r == S_FETCH) begin
        {addr_r, reg_r, data_r} <= i_entry;
      end
      if (state_r == S_ISSUE) begin
        timeout_cnt_r <= {TO_W{1'b0}};
      end else if (state_r == S_WAIT) begin
        timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
      end
      if (state_r == S_GAP && !gap_done_s) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= {GAP_W{1'b0}};
      end
    end
  end

  assign o_index       = index_r;
  assign o_begin       = begin_r;
  assign o_writeEnable = 1'b1;
  assign o_i2cAddress  = addr_r;
  assign o_regAddr     = reg_r;
  assign o_data        = data_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_error       = error_r;
  assign o_failIndex   = fail_index_r;

endmodule
